bidir_bus_xcvr: RTL and testbench
=================================

# bidir_bus_xcvr

Parametrised, clocked bidirectional bus transceiver between two tri-state ports `a` and `b`. It replaces direct gating of both buffer directions from `ce`/`sr` with a registered direction state machine. That machine guarantees a configurable dead (both-hi-Z) turnaround interval on every direction reversal, so the two sides are never driven at once. It sits between two shared buses and reports its drive state to the bus arbiter.

## Interface
- `WIDTH`, 8: bus width in bits (≥1).
- `TURN_CYCLES`, 2: dead cycles inserted on a direction reversal (1–15).
- `clk`  input  1  clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ce`  input  1  transceiver enable; 0 = both ports hi-Z.
- `sr`  input  1  requested direction; 1 = a→b, 0 = b→a.
- `a`  inout  WIDTH  port A.
- `b`  inout  WIDTH  port B.
- `a_oe`  output  1  1 while the block drives `a` (b→a).
- `b_oe`  output  1  1 while the block drives `b` (a→b).
- `busy`  output  1  1 during turnaround.
- `rev_cnt`  output  8  saturating count of completed direction reversals.

## Operation
- States: IDLE, DRV_AB, DRV_BA, TURN.
- IDLE: both ports hi-Z. With `ce`=1, go next cycle to DRV_AB if `sr`=1, else DRV_BA. No dead cycle from IDLE.
- DRV_AB: `b` is driven from `a`, `b_oe`=1. If `ce`=0, go to IDLE. If `ce`=1 and `sr`=0, go to TURN.
- DRV_BA: `a` is driven from `b`, `a_oe`=1. If `ce`=0, go to IDLE. If `ce`=1 and `sr`=1, go to TURN.
- TURN: both ports hi-Z, `busy`=1. A down-counter is loaded with TURN_CYCLES−1 on entry.
  - If `ce`=0 at any cycle, go to IDLE and abandon the count. `rev_cnt` is unchanged.
  - When the counter reaches 0, go to the drive state selected by the `sr` sampled that cycle.
  - `rev_cnt` increments only if that state differs from the pre-TURN drive state.
  - If `sr` toggles back mid-TURN, the full dead interval still completes. The block then resumes the original direction and `rev_cnt` is not incremented.
- `rev_cnt` saturates at 255. It clears only on reset.
- `a_oe` and `b_oe` are decoded from registered state only, so they are never 1 together, including across reset.
- Reset mid-operation clears the state to IDLE and releases both ports asynchronously, with no dead-cycle requirement.

## Timing
- Reset values: state IDLE, `a_oe`=0, `b_oe`=0, `busy`=0, `rev_cnt`=0, `a`/`b` hi-Z, data latch 0.
- `ce`/`sr` change to drive enable: 1 cycle from IDLE.
- Reversal: 1 cycle to enter TURN, TURN_CYCLES cycles hi-Z, then the new drive state. Total `sr` edge to new `oe` is TURN_CYCLES+1 cycles.
- Disable: `oe` falls 1 cycle after `ce` is sampled 0.
- Simultaneous `ce`=0 and `sr` change: disable wins and the next state is IDLE.
- Data path without the macro: combinational pass-through, gated by registered `oe`.

## Configuration
- `BIDIR_XCVR_LATCH_EN`:
  - Defined: the driven value is registered from the source port every cycle, giving 1 cycle of data latency.
  - Defined: on entry to TURN or IDLE, the last driven word is held internally. On return to the same direction, it is re-driven in the first drive cycle until the first new sample.
  - Undefined: no data registers; 0 cycles of data latency.

## Structure
- Package `bidir_xcvr_pkg`: state enum `xcvr_state_t` (IDLE, DRV_AB, DRV_BA, TURN), the `rev_cnt` width constant, and the direction encoding constants DIR_AB=1 / DIR_BA=0.
- One sub-module, `xcvr_turn_timer`: a loadable 4-bit down-counter with a `done` output, used by TURN.

## Test plan
- Reset with `rst_n`=0, then `ce`=1, `sr`=1, `a`=8'hA5 → after 1 cycle `b_oe`=1, `a_oe`=0, `b`=8'hA5 (next cycle with the macro); `a` is never driven.
- While in DRV_AB, drop `sr` to 0 with TURN_CYCLES=2 and `b` driven externally to 8'h3C → `busy`=1 for exactly 2 cycles with both ports hi-Z, then `a_oe`=1, `a`=8'h3C, `rev_cnt`=1.
- In TURN, return `sr` to 1 before the count ends → the full 2 dead cycles elapse, the block resumes DRV_AB, and `rev_cnt` is unchanged.
- In TURN, set `ce`=0 → next cycle IDLE, `busy`=0, both `oe`=0, `rev_cnt` unchanged.
- Perform 260 reversals → `rev_cnt` saturates at 255; a checker asserts `a_oe` and `b_oe` are never 1 together.
- Assert `rst_n`=0 asynchronously mid-DRV_BA → `a_oe`=0 without a clock edge and all outputs return to their reset values.

Source files
------------

// File: rtl/bidir_xcvr_pkg.sv
// rtl/bidir_xcvr_pkg.sv - shared types and constants for the bidirectional bus transceiver
package bidir_xcvr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRV_AB = 2'd1,
        DRV_BA = 2'd2,
        TURN   = 2'd3
    } xcvr_state_t;

    localparam int REV_CNT_W = 8;

    localparam logic DIR_AB = 1'b1;
    localparam logic DIR_BA = 1'b0;

    // Drive state that corresponds to a requested direction
    function automatic xcvr_state_t drive_state(input logic dir);
        return (dir == DIR_AB) ? DRV_AB : DRV_BA;
    endfunction

endpackage

// File: rtl/xcvr_turn_timer.sv
// rtl/xcvr_turn_timer.sv - loadable 4-bit down-counter timing the dead turnaround interval
module xcvr_turn_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [3:0] cnt;

    // Load on TURN entry, then count down to zero and stop there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign done = (cnt == 4'd0);

endmodule

// File: rtl/bidir_bus_xcvr.sv
// rtl/bidir_bus_xcvr.sv - registered-direction bus transceiver with dead turnaround (option: BIDIR_XCVR_LATCH_EN)
module bidir_bus_xcvr
    import bidir_xcvr_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce,
    input  logic                 sr,
    inout  wire  [WIDTH-1:0]     a,
    inout  wire  [WIDTH-1:0]     b,
    output logic                 a_oe,
    output logic                 b_oe,
    output logic                 busy,
    output logic [REV_CNT_W-1:0] rev_cnt
);

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    xcvr_state_t state;
    xcvr_state_t next_state;
    xcvr_state_t pre_turn;
    logic        enter_turn;
    logic        rev_inc;
    logic        t_done;

    xcvr_turn_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (enter_turn),
        .load_val (TURN_LOAD),
        .en       (state == TURN),
        .done     (t_done)
    );

    // Next-state decode; disable always wins over a direction request
    always_comb begin
        next_state = state;
        rev_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (ce) next_state = drive_state(sr);
            end
            DRV_AB: begin
                if (!ce)                 next_state = IDLE;
                else if (sr == DIR_BA)   next_state = TURN;
            end
            DRV_BA: begin
                if (!ce)                 next_state = IDLE;
                else if (sr == DIR_AB)   next_state = TURN;
            end
            default: begin
                if (!ce) begin
                    next_state = IDLE;
                end else if (t_done) begin
                    next_state = drive_state(sr);
                    rev_inc    = (drive_state(sr) != pre_turn);
                end
            end
        endcase
        enter_turn = (state != TURN) && (next_state == TURN);
    end

    // State register; reset releases both ports immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Remember the direction in force before the turnaround
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pre_turn <= IDLE;
        else if (enter_turn) pre_turn <= state;
    end

    // Saturating count of completed reversals
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       rev_cnt <= '0;
        else if (rev_inc && (rev_cnt != '1)) rev_cnt <= rev_cnt + 1'b1;
    end

    assign a_oe = (state == DRV_BA);
    assign b_oe = (state == DRV_AB);
    assign busy = (state == TURN);

`ifdef BIDIR_XCVR_LATCH_EN
    logic [WIDTH-1:0] lat;

    // Sample the source port while driving; hold the last word otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               lat <= '0;
        else if (state == DRV_AB) lat <= a;
        else if (state == DRV_BA) lat <= b;
    end

    assign b = b_oe ? lat : {WIDTH{1'bz}};
    assign a = a_oe ? lat : {WIDTH{1'bz}};
`else
    assign b = b_oe ? a : {WIDTH{1'bz}};
    assign a = a_oe ? b : {WIDTH{1'bz}};
`endif

endmodule

// File: tb/tb_bidir_bus_xcvr.sv
// tb/tb_bidir_bus_xcvr.sv - randomized self-checking bench for bidir_bus_xcvr against a direction model
module tb_bidir_bus_xcvr;

    localparam int W  = 8;
    localparam int TC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic         sr;
    logic [W-1:0] a_drv;
    logic [W-1:0] b_drv;
    logic         a_en;
    logic         b_en;
    wire  [W-1:0] a;
    wire  [W-1:0] b;
    logic         a_oe;
    logic         b_oe;
    logic         busy;
    logic [7:0]   rev_cnt;

    assign a = a_en ? a_drv : {W{1'bz}};
    assign b = b_en ? b_drv : {W{1'bz}};

    bidir_bus_xcvr #(.WIDTH(W), .TURN_CYCLES(TC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .sr      (sr),
        .a       (a),
        .b       (b),
        .a_oe    (a_oe),
        .b_oe    (b_oe),
        .busy    (busy),
        .rev_cnt (rev_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 = hi-Z, 1 = a->b, 2 = b->a; dead = remaining turnaround cycles
    int         m_mode;
    int         m_dead;
    int         m_origin;
    int         m_rev;
    logic [W-1:0] m_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_a_oe();
        return (m_mode == 2) && (m_dead == 0);
    endfunction

    function automatic logic exp_b_oe();
        return (m_mode == 1) && (m_dead == 0);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_dead = 0; m_origin = 0; m_rev = 0; m_lat = '0;
    endtask

    task automatic model_edge();
        int want;
        want = sr ? 1 : 2;
        if (exp_b_oe()) m_lat = a_drv;
        if (exp_a_oe()) m_lat = b_drv;
        if (m_dead > 0) begin
            if (!ce) begin
                m_dead = 0;
                m_mode = 0;
            end else begin
                m_dead--;
                if (m_dead == 0) begin
                    m_mode = want;
                    if (want != m_origin && m_rev < 255) m_rev++;
                end
            end
        end else if (m_mode == 0) begin
            if (ce) m_mode = want;
        end else if (!ce) begin
            m_mode = 0;
        end else if (want != m_mode) begin
            m_origin = m_mode;
            m_mode   = 0;
            m_dead   = TC;
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] exp_b;
        logic [W-1:0] exp_a;
`ifdef BIDIR_XCVR_LATCH_EN
        exp_b = m_lat;
        exp_a = m_lat;
`else
        exp_b = a_drv;
        exp_a = b_drv;
`endif
        check("a_oe", 32'(a_oe), 32'(exp_a_oe()));
        check("b_oe", 32'(b_oe), 32'(exp_b_oe()));
        check("busy", 32'(busy), 32'(m_dead > 0));
        check("rev_cnt", 32'(rev_cnt), 32'(m_rev));
        check("oe_excl", 32'(a_oe & b_oe), 32'd0);
        if (exp_b_oe()) check("b_data", 32'(b), 32'(exp_b));
        if (exp_a_oe()) check("a_data", 32'(a), 32'(exp_a));
    endtask

    // One clock: apply inputs, advance model on the edge, release/grab the bus, check at negedge
    task automatic step(input logic ce_i, input logic sr_i, input logic [W-1:0] av, input logic [W-1:0] bv);
        ce = ce_i; sr = sr_i; a_drv = av; b_drv = bv;
        @(posedge clk);
        model_edge();
        #1;
        a_en = !exp_a_oe();
        b_en = !exp_b_oe();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; sr = 1'b0;
        a_drv = '0; b_drv = '0; a_en = 1'b1; b_en = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Enable a->b
        step(1'b1, 1'b1, 8'hA5, 8'h00);
        check("first_b", 32'(b), 32'h0A5);

        // Reverse to b->a: two dead cycles then drive a
        step(1'b1, 1'b0, 8'h11, 8'h3C);
        check("turn1_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 8'h11, 8'h3C);
        check("turn2_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 8'h11, 8'h3C);
        check("rev_a_oe", 32'(a_oe), 32'd1);
        check("rev_a", 32'(a), 32'h03C);
        check("rev_cnt1", 32'(rev_cnt), 32'd1);

        // Request reversal then cancel it mid-turnaround
        step(1'b1, 1'b1, 8'h22, 8'h44);
        step(1'b1, 1'b0, 8'h22, 8'h44);
        check("cancel_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 8'h22, 8'h44);
        check("cancel_resume", 32'(a_oe), 32'd1);
        check("cancel_rev", 32'(rev_cnt), 32'd1);

        // Disable during turnaround
        step(1'b1, 1'b1, 8'h55, 8'h66);
        step(1'b0, 1'b1, 8'h55, 8'h66);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rev", 32'(rev_cnt), 32'd1);

        // Randomized operation
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0) ? ~sr : sr,
                 W'($urandom), W'($urandom));
        end

        // Saturation of the reversal counter
        step(1'b1, 1'b1, 8'h01, 8'h02);
        for (int r = 0; r < 260; r++) begin
            for (int k = 0; k < TC + 1; k++) begin
                step(1'b1, r[0], W'($urandom), W'($urandom));
            end
        end
        check("rev_sat", 32'(rev_cnt), 32'd255);

        // Asynchronous reset while driving a
        step(1'b1, 1'b0, 8'h77, 8'h88);
        step(1'b1, 1'b0, 8'h77, 8'h88);
        step(1'b1, 1'b0, 8'h77, 8'h88);
        step(1'b1, 1'b0, 8'h77, 8'h88);
        check("pre_rst_a_oe", 32'(a_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        a_en = 1'b1; b_en = 1'b1;
        check("async_a_oe", 32'(a_oe), 32'd0);
        check("async_rev", 32'(rev_cnt), 32'd0);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h99, 8'hC3);
        check("post_rst_a", 32'(a), 32'h0C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
